// File: rtl/ttt_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ttt_game_ctrl_if
// Description : Key-code input and board/status outputs of the game controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ttt_game_ctrl_if;
   logic [3:0]  key_data;
   logic [17:0] board;
   logic        turn_o;
   logic [1:0]  winner;
   logic        game_over;
   logic [3:0]  move_cnt;
   logic        illegal;

   modport master (
      output key_data,
      input  board, turn_o, winner, game_over, move_cnt, illegal
   );

   modport slave (
      input  key_data,
      output board, turn_o, winner, game_over, move_cnt, illegal
   );
endinterface
`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ttt_game_ctrl
// Description : Debounces keypad codes into presses and runs tic-tac-toe play
//               (placement, turn alternation, win/draw detection).
//               Optional one-level undo on '#' when TTT_UNDO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_game_ctrl #(
   parameter int DEBOUNCE_CYCLES = 12500
) (
   input  logic           clk,
   input  logic           rst,
   ttt_game_ctrl_if.slave bus
);

   localparam int              CW        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]   C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   C_CNT_PRE = CW'(DEBOUNCE_CYCLES - 2);
   localparam logic [3:0]      C_KEY_STAR = 4'd10;

   localparam logic [1:0] S_PLAY  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [3:0]    key_prev_q;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic          armed_q, armed_d;
   logic          stable, press;

   logic [1:0]    state_q, state_d;
   logic [17:0]   board_q, board_d;
   logic          turn_q, turn_d;
   logic [1:0]    winner_q, winner_d;
   logic [3:0]    mcnt_q, mcnt_d;
   logic          illegal_q, illegal_d;

   logic          is_cell;
   logic [3:0]    cell_idx;
   logic [1:0]    cell_val;
   logic [1:0]    line_val;

`ifdef TTT_UNDO_EN
   localparam logic [3:0] C_KEY_HASH = 4'd11;
   logic [3:0] last_q, last_d;
   logic       undo_q, undo_d;
`endif

   // A press is the increment that takes the stable-count to DEBOUNCE_CYCLES-1.
   assign stable = (bus.key_data != 4'd0) && (bus.key_data == key_prev_q);
   assign press  = armed_q && stable && (db_cnt_q == C_CNT_PRE);

   always_comb begin
      db_cnt_d = '0;
      if (stable) begin
         db_cnt_d = (db_cnt_q == C_CNT_MAX) ? db_cnt_q : db_cnt_q + CW'(1);
      end
      armed_d = armed_q;
      if (bus.key_data == 4'd0) begin
         armed_d = 1'b1;
      end else if (press) begin
         armed_d = 1'b0;
      end
   end

   function automatic logic [1:0] cell_at(input logic [17:0] b, input int n);
      return b[2*n +: 2];
   endfunction

   function automatic logic [1:0] line3(input logic [17:0] b, input int x, input int y, input int z);
      logic [1:0] a;
      a = cell_at(b, x);
      return ((a != 2'd0) && (a == cell_at(b, y)) && (a == cell_at(b, z))) ? a : 2'd0;
   endfunction

   // Every completed line belongs to the same mover, so OR-ing them is exact.
   assign line_val = line3(board_q, 0, 1, 2) | line3(board_q, 3, 4, 5) | line3(board_q, 6, 7, 8)
                   | line3(board_q, 0, 3, 6) | line3(board_q, 1, 4, 7) | line3(board_q, 2, 5, 8)
                   | line3(board_q, 0, 4, 8) | line3(board_q, 2, 4, 6);

   assign is_cell  = (bus.key_data >= 4'd1) && (bus.key_data <= 4'd9);
   assign cell_idx = is_cell ? (bus.key_data - 4'd1) : 4'd0;
   assign cell_val = board_q[{cell_idx, 1'b0} +: 2];

   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      turn_d    = turn_q;
      winner_d  = winner_q;
      mcnt_d    = mcnt_q;
      illegal_d = 1'b0;
`ifdef TTT_UNDO_EN
      last_d    = last_q;
      undo_d    = undo_q;
`endif
      case (state_q)
         S_PLAY: begin
            if (press) begin
               if (is_cell) begin
                  if (cell_val == 2'd0) begin
                     board_d[{cell_idx, 1'b0} +: 2] = turn_q ? 2'd2 : 2'd1;
                     mcnt_d  = mcnt_q + 4'd1;
                     state_d = S_CHECK;
`ifdef TTT_UNDO_EN
                     last_d  = cell_idx;
                     undo_d  = 1'b1;
`endif
                  end else begin
                     illegal_d = 1'b1;
                  end
               end else if (bus.key_data == C_KEY_STAR) begin
                  board_d  = '0;
                  turn_d   = 1'b0;
                  winner_d = 2'd0;
                  mcnt_d   = 4'd0;
`ifdef TTT_UNDO_EN
                  undo_d   = 1'b0;
               end else if (bus.key_data == C_KEY_HASH) begin
                  if (undo_q && (mcnt_q != 4'd0)) begin
                     board_d[{last_q, 1'b0} +: 2] = 2'd0;
                     mcnt_d = mcnt_q - 4'd1;
                     turn_d = ~turn_q;
                     undo_d = 1'b0;
                  end else begin
                     illegal_d = 1'b1;
                  end
`else
               end else begin
                  state_d = S_PLAY;
`endif
               end
            end
         end
         S_CHECK: begin
            if (line_val != 2'd0) begin
               winner_d = line_val;
               state_d  = S_DONE;
            end else if (mcnt_q == 4'd9) begin
               winner_d = 2'd3;
               state_d  = S_DONE;
            end else begin
               turn_d  = ~turn_q;
               state_d = S_PLAY;
            end
         end
         S_DONE: begin
            if (press) begin
               if (is_cell) begin
                  illegal_d = 1'b1;
               end else if (bus.key_data == C_KEY_STAR) begin
                  board_d  = '0;
                  turn_d   = 1'b0;
                  winner_d = 2'd0;
                  mcnt_d   = 4'd0;
                  state_d  = S_PLAY;
`ifdef TTT_UNDO_EN
                  undo_d   = 1'b0;
               end else if ((bus.key_data == C_KEY_HASH) && undo_q) begin
                  // turn_q already holds the final mover, who moves again.
                  board_d[{last_q, 1'b0} +: 2] = 2'd0;
                  mcnt_d   = mcnt_q - 4'd1;
                  winner_d = 2'd0;
                  undo_d   = 1'b0;
                  state_d  = S_PLAY;
`endif
               end
            end
         end
         default: state_d = S_PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_prev_q <= 4'd0;
         db_cnt_q   <= '0;
         armed_q    <= 1'b1;
         state_q    <= S_PLAY;
         board_q    <= '0;
         turn_q     <= 1'b0;
         winner_q   <= 2'd0;
         mcnt_q     <= 4'd0;
         illegal_q  <= 1'b0;
      end else begin
         key_prev_q <= bus.key_data;
         db_cnt_q   <= db_cnt_d;
         armed_q    <= armed_d;
         state_q    <= state_d;
         board_q    <= board_d;
         turn_q     <= turn_d;
         winner_q   <= winner_d;
         mcnt_q     <= mcnt_d;
         illegal_q  <= illegal_d;
      end
   end

`ifdef TTT_UNDO_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 4'd0;
         undo_q <= 1'b0;
      end else begin
         last_q <= last_d;
         undo_q <= undo_d;
      end
   end
`endif

   assign bus.board     = board_q;
   assign bus.turn_o    = turn_q;
   assign bus.winner    = winner_q;
   assign bus.game_over = (state_q == S_DONE);
   assign bus.move_cnt  = mcnt_q;
   assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttt_game_ctrl
// Description : Scoreboard bench for ttt_game_ctrl with a board-level game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_game_ctrl;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ttt_game_ctrl_if bus ();

   ttt_game_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          cyc;
      int          key;
      int          phase;
      logic [17:0] board;
      logic        turn;
      logic [1:0]  winner;
      logic        over;
      logic [3:0]  cnt;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Game model: cells hold 0 empty, 1 X, 2 O.
   int   cells[9];
   bit   turn;
   int   winner, mcnt, last;
   bit   over, undo_ok;
   int   lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic exp_t snap(input int c, input int k, input int ph, input bit ill);
      exp_t e;
      e.cyc = c; e.key = k; e.phase = ph;
      e.board = '0;
      for (int n = 0; n < 9; n++) e.board[2*n +: 2] = 2'(cells[n]);
      e.turn = turn; e.winner = 2'(winner); e.over = over; e.cnt = 4'(mcnt); e.ill = ill;
      return e;
   endfunction

   task automatic model_new();
      for (int n = 0; n < 9; n++) cells[n] = 0;
      turn = 1'b0; winner = 0; mcnt = 0; over = 1'b0; undo_ok = 1'b0; last = 0;
   endtask

   // p = cycle in which the debounced press occurs.
   task automatic model_press(input int k, input int p, input bit full);
      bit ill;
      bit placed;
      int w;
      ill = 1'b0; placed = 1'b0; w = 0;
      if (k >= 1 && k <= 9) begin
         if (over || cells[k-1] != 0) begin
            ill = 1'b1;
         end else begin
            cells[k-1] = turn ? 2 : 1;
            mcnt++; last = k - 1; undo_ok = 1'b1; placed = 1'b1;
         end
      end else if (k == 10) begin
         model_new();
      end
`ifdef TTT_UNDO_EN
      else if (k == 11) begin
         if (over) begin
            if (undo_ok) begin
               cells[last] = 0; mcnt--; winner = 0; over = 1'b0; undo_ok = 1'b0;
            end
         end else if (undo_ok && mcnt > 0) begin
            cells[last] = 0; mcnt--; turn = ~turn; undo_ok = 1'b0;
         end else begin
            ill = 1'b1;
         end
      end
`endif
      sb.push_back(snap(p + 1, k, 0, ill));
      if (placed) begin
         for (int i = 0; i < 8; i++)
            if (cells[lines[i][0]] != 0 && cells[lines[i][0]] == cells[lines[i][1]]
                && cells[lines[i][0]] == cells[lines[i][2]])
               w = cells[lines[i][0]];
         if (w != 0) begin
            winner = w; over = 1'b1;
         end else if (mcnt == 9) begin
            winner = 3; over = 1'b1;
         end else begin
            turn = ~turn;
         end
      end
      if (full) sb.push_back(snap(p + 2, k, 1, 1'b0));
   endtask

   task automatic press_key(input int k);
      int kc;
      @(posedge clk); #1;
      bus.key_data = 4'(k);
      kc = cyc;
      model_press(k, kc + D - 1, 1'b1);
      repeat (D + $urandom_range(0, 3)) @(posedge clk);
      #1 bus.key_data = 4'd0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
   endtask

   task automatic play(input int seq[$]);
      foreach (seq[i]) press_key(seq[i]);
   endtask

   always @(negedge clk) begin
      exp_t r;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         r = sb.pop_front();
         checks++;
         if (r.cyc != cyc || bus.board !== r.board || bus.turn_o !== r.turn ||
             bus.winner !== r.winner || bus.game_over !== r.over ||
             bus.move_cnt !== r.cnt || bus.illegal !== r.ill) begin
            errors++;
            $display("FAIL %s key=%0d cyc=%0d: got board=%h turn=%0b winner=%0d over=%0b cnt=%0d ill=%0b, expected board=%h turn=%0b winner=%0d over=%0b cnt=%0d ill=%0b (cyc %0d)",
                     (r.phase == 0) ? "after_press" : (r.phase == 1) ? "after_check" : "idle",
                     r.key, cyc, bus.board, bus.turn_o, bus.winner, bus.game_over, bus.move_cnt,
                     bus.illegal, r.board, r.turn, r.winner, r.over, r.cnt, r.ill, r.cyc);
         end
      end
   end

   initial begin
      int kc;
      int k;
      int r;
      bus.key_data = 4'd0;
      model_new();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      sb.push_back(snap(cyc, 0, 2, 1'b0));

      // Alternating key must never debounce into a press.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         bus.key_data = (i % 2 == 0) ? 4'd5 : 4'd0;
      end
      @(posedge clk); #1;
      bus.key_data = 4'd0;
      sb.push_back(snap(cyc + 2, 0, 2, 1'b0));
      repeat (3) @(posedge clk);

      play('{5});
      play('{10, 1, 4, 2, 5, 3, 6});
      play('{10, 1, 2, 3, 5, 4, 6, 8, 7, 9, 5, 10});
      play('{5, 5, 12, 15, 11});
`ifdef TTT_UNDO_EN
      play('{10, 1, 4, 11, 11, 4});
      play('{10, 1, 4, 2, 5, 3, 11, 6, 3});
`endif

      // Reset while the controller sits in CHECK.
      press_key(10);
      @(posedge clk); #1;
      bus.key_data = 4'd5;
      kc = cyc;
      model_press(5, kc + D - 1, 1'b0);
      repeat (D) @(posedge clk);
      #1 rst = 1'b1;
      bus.key_data = 4'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_new();
      sb.push_back(snap(cyc, 0, 2, 1'b0));
      repeat (2) @(posedge clk);

      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 19);
         if (r < 14)      k = $urandom_range(1, 9);
         else if (r < 16) k = 10;
         else if (r < 18) k = 11;
         else             k = $urandom_range(12, 15);
         press_key(k);
      end

      for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected responses never compared, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Game-logic stage of the tic-tac-toe design: consumes the raw key code from the keypad scanner, debounces it into single presses, places X/O stones on a 3x3 board, alternates turns, and detects win/draw. Its `board` output drives the dot-matrix renderer directly, and its status outputs feed the 7-segment banner logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 12500: consecutive stable `clk` cycles a nonzero key code must hold before it counts as a press.

Ports:
- `clk`  in  1: system clock, 25 MHz.
- `rst`  in  1: reset, synchronous and active-high.
- `key_data`  in  4: scanner code; 0 = no key, 1–9 = cells, 10 = '*', 11 = '#', 12–15 ignored.
- `board`  out  18: cell n (1–9) at `board[2n-1:2n-2]`; 0 = empty, 1 = X, 2 = O, 3 never produced.
- `turn_o`  out  1: 1 = O to move, 0 = X to move.
- `winner`  out  2: 0 none, 1 X, 2 O, 3 draw.
- `game_over`  out  1: high in DONE.
- `move_cnt`  out  4: stones on board, 0–9.
- `illegal`  out  1: one-cycle pulse on a rejected press.

## Operation
- Debouncer: registers previous `key_data`. Counter clears whenever `key_data` changes or is 0; otherwise increments, saturating. On the cycle the counter reaches `DEBOUNCE_CYCLES-1`, internal `press` pulses for one cycle with `press_code` = `key_data`. Re-arms only after `key_data` is 0 for at least one cycle; a held key yields exactly one press.
- FSM states PLAY, CHECK, DONE. Reset → PLAY.
- PLAY, press 1–9, cell empty: write 1 (X, `turn_o`=0) or 2 (O) to cell, `move_cnt`+1, → CHECK.
- PLAY, press 1–9, cell occupied: `illegal` pulse, no state change.
- PLAY, press 10 ('*'): new game (board 0, `turn_o` 0, `winner` 0, `move_cnt` 0), stay PLAY.
- PLAY, press 11–15: ignored.
- CHECK (one cycle): evaluate 3 rows, 3 columns, 2 diagonals on the registered board. Any line of three equal nonzero cells → `winner` = that value, `game_over` 1, → DONE. Else if `move_cnt` = 9 → `winner` 3, → DONE. Else toggle `turn_o`, → PLAY. Presses arriving in CHECK are dropped silently.
- DONE: press 10 → new game, → PLAY. Press 1–9 → `illegal` pulse. Others ignored. Board frozen.
- Only the mover can complete a line, so one winner per check; multiple simultaneous lines report that mover.

## Timing
- Reset values: `board` 0, `turn_o` 0, `winner` 0, `game_over` 0, `move_cnt` 0, `illegal` 0, debounce counter 0, armed.
- `rst` overrides everything in the same edge, including mid-CHECK and mid-debounce.
- Press-to-board latency: `board` updates at the edge after `press` (cycle P+1); `winner`/`game_over`/`turn_o` update at P+2.
- Key stable from cycle K: `press` at K+`DEBOUNCE_CYCLES`-1; `board` at K+`DEBOUNCE_CYCLES`.
- `illegal` asserted in cycle P+1 for exactly one cycle.
- `turn_o` is not toggled by a move that ends the game; it shows the final mover.

## Configuration
- `TTT_UNDO_EN`: when defined, '#' (11) in PLAY with `move_cnt` > 0 clears the last-placed cell, decrements `move_cnt`, toggles `turn_o` back; one level only (a second '#' before another move → `illegal`). '#' in DONE after a win/draw undoes the final move, clears `winner`/`game_over`, returns to PLAY with `turn_o` = that mover. Undo register cleared by reset and new game. When undefined, '#' is ignored in all states and no undo storage is built.

## Test plan
- Reset, `DEBOUNCE_CYCLES`=4, hold `key_data`=5 for 10 cycles then 0 → `board`=18'h00100 (cell 5 = X) at cycle 4, exactly one placement, `turn_o`=1 two cycles after press.
- Bounce: `key_data` 5,0,5,0 alternating each cycle for 20 cycles → no press, `board` stays 0.
- Moves 1,4,2,5,3 → after last, `winner`=1, `game_over`=1, `move_cnt`=5; then key 6 → `illegal` one cycle, board unchanged.
- Moves 1,2,3,5,4,6,8,7,9 → `winner`=3, `move_cnt`=9; key 10 → all outputs back to reset values, state PLAY.
- Press 5 twice (second after release) → second press gives `illegal`, `turn_o` remains 1, `move_cnt`=1.
- `TTT_UNDO_EN`: moves 1,4 then '#' → cell 4 cleared, `move_cnt`=1, `turn_o`=1; second '#' → `illegal`. Assert `rst` during CHECK → all outputs zero next cycle.
